// File: rtl/noc_input_buffer_bank_pkg.sv
// -----------------------------------------------------------------------------
// noc package: shared types and constants for the stop/void NoC link buffers.
//
// Contents:
//   kNumPorts  - number of router ports (N, S, W, E, P)
//   AllPorts   - enable mask with every port present
//   port_e     - port index enum, bit 0 of every port vector is North
//   preamble_t - flit preamble carried in the top bits of each flit
//   cnt_width  - width of an occupancy counter able to hold 0..depth
//
// Optional feature macro used by the bank: NOC_INPUT_BUFFER_BYPASS_EN
// -----------------------------------------------------------------------------
package noc;

   localparam int kNumPorts = 5;
   localparam logic [kNumPorts-1:0] AllPorts = 5'b11111;

   typedef enum logic [2:0] {
      kNorthPort = 3'd0,
      kSouthPort = 3'd1,
      kWestPort  = 3'd2,
      kEastPort  = 3'd3,
      kLocalPort = 3'd4
   } port_e;

   typedef struct packed {
      logic       head;
      logic       tail;
      logic [1:0] vc;
   } preamble_t;

   // Counter must represent the full state (Depth entries), hence depth+1.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/noc_input_buffer_bank_fifo.sv
// -----------------------------------------------------------------------------
// noc_stop_void_fifo: one port's stop/void input FIFO.
//
// Ports:
//   i_clk, i_rst_n    - clock, asynchronous active-low reset
//   i_data, i_void    - incoming flit and its "no flit" flag
//   i_stop            - downstream refuses the head this cycle
//   o_data, o_void    - head flit and its "invalid" flag
//   o_stop            - registered back-pressure towards upstream
//   o_overflow        - sticky: a flit arrived while the FIFO was full
//
// Optional feature: NOC_INPUT_BUFFER_BYPASS_EN lets a flit arriving at an
// empty FIFO with i_stop low go straight to o_data in the same cycle.
// -----------------------------------------------------------------------------
module noc_stop_void_fifo
   import noc::*;
#(
   parameter int Width      = 32,
   parameter int Depth      = 4,
   parameter int StopMargin = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [Width-1:0] i_data,
   input  logic             i_void,
   input  logic             i_stop,
   output logic [Width-1:0] o_data,
   output logic             o_void,
   output logic             o_stop,
   output logic             o_overflow
);

   localparam int CW = cnt_width(Depth);
   localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [CW-1:0] DepthC     = CW'(Depth);
   localparam logic [CW-1:0] StopThresh = CW'(Depth - StopMargin);
   localparam logic [PW-1:0] LastPtr    = PW'(Depth - 1);

   logic [Width-1:0] r_mem [Depth];
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [Width-1:0] r_head;
   logic             r_void;
   logic             r_stop;
   logic             r_overflow;

   logic             w_bypass;
   logic             w_pop;
   logic             w_full;
   logic             w_push;
   logic             w_drop;
   logic [CW-1:0]    w_cnt_next;
   logic [PW-1:0]    w_wr_ptr_next;
   logic [PW-1:0]    w_rd_ptr_next;
   logic [Width-1:0] w_head_next;

`ifdef NOC_INPUT_BUFFER_BYPASS_EN
   assign w_bypass = (r_cnt == '0) && !i_void && !i_stop;
   assign o_data   = w_bypass ? i_data : r_head;
   assign o_void   = r_void && !w_bypass;
`else
   assign w_bypass = 1'b0;
   assign o_data   = r_head;
   assign o_void   = r_void;
`endif

   assign o_stop     = r_stop;
   assign o_overflow = r_overflow;

   always_comb begin
      // A pop only ever consumes a stored entry, never a bypassed flit.
      w_pop  = !r_void && !i_stop;
      // Full-with-pop frees a slot in the same cycle, so it still accepts.
      w_full = (r_cnt == DepthC) && !w_pop;
      w_push = !i_void && !w_full && !w_bypass;
      w_drop = !i_void && w_full;

      w_cnt_next = r_cnt + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

      w_wr_ptr_next = r_wr_ptr;
      if (w_push) begin
         w_wr_ptr_next = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PW'(1);
      end
      w_rd_ptr_next = r_rd_ptr;
      if (w_pop) begin
         w_rd_ptr_next = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PW'(1);
      end

      // Head register: takes the incoming flit when it becomes the only
      // entry, otherwise the next stored entry after a pop; holds when empty.
      w_head_next = r_head;
      if (w_bypass) begin
         w_head_next = i_data;
      end else if (w_cnt_next != '0) begin
         if ((r_cnt == '0) || ((r_cnt == CW'(1)) && w_pop)) begin
            w_head_next = i_data;
         end else if (w_pop) begin
            w_head_next = r_mem[w_rd_ptr_next];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_head     <= '0;
         r_void     <= 1'b1;
         r_stop     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_next;
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
         r_head   <= w_head_next;
         r_void   <= (w_cnt_next == '0);
         r_stop   <= (w_cnt_next >= StopThresh);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_input_buffer_bank.sv
// -----------------------------------------------------------------------------
// noc_input_buffer_bank: five independent stop/void input FIFOs placed between
// the tile link wires and the router inputs. Disabled ports carry no storage.
//
// Ports (all vectors indexed N=0, S, W, E, P=4):
//   i_clk, i_rst_n     - clock, asynchronous active-low reset
//   i_data_in          - incoming flit per port
//   i_data_void_in     - 1 = no flit on that port this cycle
//   o_stop_out         - registered back-pressure to upstream
//   o_data_out         - head flit per port
//   o_data_void_out    - 1 = head invalid
//   i_stop_in          - router refuses the head this cycle
//   o_overflow         - sticky flag: flit arrived while the FIFO was full
//
// Optional feature macro: NOC_INPUT_BUFFER_BYPASS_EN (0-cycle bypass path
// when a port is empty and not stopped).
// -----------------------------------------------------------------------------
module noc_input_buffer_bank
   import noc::*;
#(
   parameter int Width      = 32,
   parameter int Depth      = 4,
   parameter int StopMargin = 1,
   parameter logic [kNumPorts-1:0] Ports = AllPorts
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [kNumPorts-1:0][Width-1:0] i_data_in,
   input  logic [kNumPorts-1:0]            i_data_void_in,
   output logic [kNumPorts-1:0]            o_stop_out,
   output logic [kNumPorts-1:0][Width-1:0] o_data_out,
   output logic [kNumPorts-1:0]            o_data_void_out,
   input  logic [kNumPorts-1:0]            i_stop_in,
   output logic [kNumPorts-1:0]            o_overflow
);

   generate
      for (genvar gi = 0; gi < kNumPorts; gi++) begin : g_port
         if (Ports[gi]) begin : g_on
            noc_stop_void_fifo #(
               .Width      (Width),
               .Depth      (Depth),
               .StopMargin (StopMargin)
            ) u_fifo (
               .i_clk      (i_clk),
               .i_rst_n    (i_rst_n),
               .i_data     (i_data_in[gi]),
               .i_void     (i_data_void_in[gi]),
               .i_stop     (i_stop_in[gi]),
               .o_data     (o_data_out[gi]),
               .o_void     (o_data_void_out[gi]),
               .o_stop     (o_stop_out[gi]),
               .o_overflow (o_overflow[gi])
            );
         end else begin : g_off
            // Absent port: looks permanently empty and never pushes back.
            assign o_data_out[gi]      = '0;
            assign o_data_void_out[gi] = 1'b1;
            assign o_stop_out[gi]      = 1'b0;
            assign o_overflow[gi]      = 1'b0;
         end
      end
   endgenerate

endmodule
